tk1_counter_seq: RTL and testbench

- Sequential owner of the Romulus-N 56-bit block counter that feeds the TK1 half of the tweakey.
- Holds the counter in LFSR bit order and advances it by one or two GF(2^56) LFSR steps on request.
- Presents the byte-reversed counter concatenated with an 8-bit domain separator as a 64-bit TK1 word to the downstream tweakey schedule, under a valid/ready handshake.
- Flags counter wrap-around, which marks the message-length limit.

---
 rtl/tk1_counter_seq_pkg.sv | 21 ++
 rtl/tk1_counter_seq_gf56_lfsr_step.sv | 12 +
 rtl/tk1_counter_seq.sv | 120 ++++++++++++
 tb/tb_tk1_counter_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tk1_counter_seq_pkg.sv
// Shared definitions for the Romulus-N TK1 block counter: widths, initial value,
// LFSR feedback taps and the sequencer state encoding.
package tk1_counter_seq_pkg;

  localparam int unsigned CTR_W = 56;

  // Counter value after init, in LFSR bit order.
  localparam logic [CTR_W-1:0] INIT_CTR = 56'h1;

  // Feedback taps for x^56 + x^7 + x^4 + x^2 + 1 (the x^0 term is the rotate).
  localparam logic [CTR_W-1:0] POLY_TAPS = 56'h94;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_WAIT    = 3'd2,
    S_STEP1   = 3'd3,
    S_STEP2   = 3'd4
  } state_e;

endpackage

// File: rtl/tk1_counter_seq_gf56_lfsr_step.sv
// One Galois LFSR step of the 56-bit block counter (pure combinational).
module gf56_lfsr_step
  import tk1_counter_seq_pkg::*;
(
  input  logic [CTR_W-1:0] ctr_i,
  output logic [CTR_W-1:0] ctr_o
);

  assign ctr_o = {ctr_i[CTR_W-2:0], ctr_i[CTR_W-1]}
               ^ (ctr_i[CTR_W-1] ? POLY_TAPS : '0);

endmodule

// File: rtl/tk1_counter_seq.sv
// Owns the Romulus-N TK1 block counter and domain byte, steps it on request and
// presents the byte-reversed counter plus domain as a 64-bit word under valid/ready.
module tk1_counter_seq
  import tk1_counter_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             load,
  input  logic [CTR_W-1:0] load_ctr_i,
  input  logic [7:0]       domain_i,
  input  logic             dom_we,
  input  logic             inc_valid,
  input  logic             inc_two,
  output logic             inc_ready,
  output logic [63:0]      tk_o,
  output logic             tk_valid,
  input  logic             tk_ready,
  output logic             ctr_wrap
);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [7:0]       dom_q, dom_d;
  logic             wrap_q, wrap_d;
  logic             two_q, two_d;
  logic             tk_valid_q, tk_valid_d;
  logic             inc_ready_q, inc_ready_d;
  logic [CTR_W-1:0] ctr_step;

  // Single stepper; STEP1 and STEP2 both feed it the current counter.
  gf56_lfsr_step u_step (
    .ctr_i (ctr_q),
    .ctr_o (ctr_step)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    ctr_d   = ctr_q;
    dom_d   = dom_q;
    wrap_d  = wrap_q;
    two_d   = two_q;

    if (init || load) begin
      // Init/load abort any in-flight step and restart presentation.
      ctr_d   = init ? INIT_CTR : load_ctr_i;
      dom_d   = domain_i;
      wrap_d  = 1'b0;
      state_d = S_PRESENT;
    end else begin
      if (dom_we) dom_d = domain_i;
      unique case (state_q)
        S_IDLE: ;
        S_PRESENT: begin
          if (inc_valid) begin
            state_d = S_STEP1;
            two_d   = inc_two;
          end else if (tk_valid_q && tk_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inc_valid) begin
            state_d = S_STEP1;
            two_d   = inc_two;
          end
        end
        S_STEP1: begin
          ctr_d   = ctr_step;
          if (ctr_step == INIT_CTR) wrap_d = 1'b1;
          state_d = two_q ? S_STEP2 : S_PRESENT;
        end
        S_STEP2: begin
          ctr_d   = ctr_step;
          if (ctr_step == INIT_CTR) wrap_d = 1'b1;
          state_d = S_PRESENT;
        end
        default: state_d = S_IDLE;
      endcase
    end

    tk_valid_d  = (state_d == S_PRESENT);
    inc_ready_d = (state_d == S_PRESENT) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      ctr_q       <= '0;
      dom_q       <= '0;
      wrap_q      <= 1'b0;
      two_q       <= 1'b0;
      tk_valid_q  <= 1'b0;
      inc_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      dom_q       <= dom_d;
      wrap_q      <= wrap_d;
      two_q       <= two_d;
      tk_valid_q  <= tk_valid_d;
      inc_ready_q <= inc_ready_d;
    end
  end

  // Byte 0 of the counter lands in the most significant byte of the word.
  always_comb begin
    tk_o[7:0] = dom_q;
    for (int i = 0; i < CTR_W / 8; i++) begin
      tk_o[63-8*i -: 8] = ctr_q[8*i +: 8];
    end
  end

  assign tk_valid  = tk_valid_q;
  assign inc_ready = inc_ready_q;
  assign ctr_wrap  = wrap_q;

endmodule

// File: tb/tb_tk1_counter_seq.sv
// Directed scoreboard bench for tk1_counter_seq: expected TK1 words are queued by
// the stimulus and popped by a monitor on every valid/ready handshake.
module tb_tk1_counter_seq;

  logic        clk = 1'b0;
  logic        rst, init, load, dom_we, inc_valid, inc_two, tk_ready;
  logic [55:0] load_ctr_i;
  logic [7:0]  domain_i;
  logic        inc_ready, tk_valid, ctr_wrap;
  logic [63:0] tk_o;

  typedef struct {
    logic [63:0] tk;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  tk1_counter_seq dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .load       (load),
    .load_ctr_i (load_ctr_i),
    .domain_i   (domain_i),
    .dom_we     (dom_we),
    .inc_valid  (inc_valid),
    .inc_two    (inc_two),
    .inc_ready  (inc_ready),
    .tk_o       (tk_o),
    .tk_valid   (tk_valid),
    .tk_ready   (tk_ready),
    .ctr_wrap   (ctr_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each consumed word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && tk_valid && tk_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", tk_o, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tk_word", tk_o, e.tk);
        check("tk_wrap", {63'h0, ctr_wrap}, {63'h0, e.wrap});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [63:0] tk, input logic wrap);
    exp_t e;
    e.tk   = tk;
    e.wrap = wrap;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drained", 64'(sb.size()), 64'h0);
    sb.delete();
  endtask

  task automatic pulse_init(input logic [7:0] dom);
    init = 1'b1;
    domain_i = dom;
    tick();
    init = 1'b0;
    check("init_latency", {63'h0, tk_valid}, 64'h1);
  endtask

  task automatic pulse_load(input logic [55:0] ctr, input logic [7:0] dom);
    load = 1'b1;
    load_ctr_i = ctr;
    domain_i = dom;
    tick();
    load = 1'b0;
  endtask

  task automatic do_inc(input logic two, input int exp_lat);
    int n = 0;
    while (!inc_ready && n < 20) begin
      tick();
      n++;
    end
    check("inc_ready", {63'h0, inc_ready}, 64'h1);
    inc_valid = 1'b1;
    inc_two   = two;
    tick();
    inc_valid = 1'b0;
    n = 1;
    while (!tk_valid && n < 10) begin
      tick();
      n++;
    end
    check("inc_latency", 64'(n), 64'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init = 1'b0; load = 1'b0; dom_we = 1'b0;
    inc_valid = 1'b0; inc_two = 1'b0; tk_ready = 1'b1;
    load_ctr_i = '0; domain_i = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_tk_o", tk_o, 64'h0);
    check("rst_flags", {61'h0, tk_valid, inc_ready, ctr_wrap}, 64'h0);

    // Increment in IDLE is ignored.
    inc_valid = 1'b1;
    tick(); tick();
    inc_valid = 1'b0;
    check("idle_ignores_inc", {63'h0, tk_valid}, 64'h0);

    expect_word(64'h0100_0000_0000_001A, 1'b0);
    pulse_init(8'h1A);
    wait_drain();

    expect_word(64'h0200_0000_0000_001A, 1'b0);
    do_inc(1'b0, 2);
    wait_drain();

    expect_word(64'h0800_0000_0000_001A, 1'b0);
    do_inc(1'b1, 3);
    wait_drain();

    // Top bit set: feedback taps fold in.
    expect_word(64'h0000_0000_0000_80DD, 1'b0);
    pulse_load(56'h80_0000_0000_0000, 8'hDD);
    wait_drain();
    expect_word(64'h9500_0000_0000_00DD, 1'b0);
    do_inc(1'b0, 2);
    wait_drain();

    // Step lands on INIT_CTR: wrap flag sets, then init clears it.
    expect_word(64'h4A00_0000_0000_805C, 1'b0);
    pulse_load(56'h80_0000_0000_004A, 8'h5C);
    wait_drain();
    expect_word(64'h0100_0000_0000_005C, 1'b1);
    do_inc(1'b0, 2);
    wait_drain();
    check("wrap_sticky", {63'h0, ctr_wrap}, 64'h1);
    expect_word(64'h0100_0000_0000_001A, 1'b0);
    pulse_init(8'h1A);
    wait_drain();

    // Init during STEP1 of a double increment aborts STEP2.
    inc_valid = 1'b1;
    inc_two   = 1'b1;
    tick();
    inc_valid = 1'b0;
    check("step1_not_ready", {63'h0, inc_ready}, 64'h0);
    expect_word(64'h0100_0000_0000_003C, 1'b0);
    pulse_init(8'h3C);
    wait_drain();

    // Domain write in WAIT shows up on tk_o next cycle.
    dom_we   = 1'b1;
    domain_i = 8'h77;
    tick();
    dom_we = 1'b0;
    check("dom_we", tk_o, 64'h0100_0000_0000_0077);

    // Back-pressure: inc held through STEP1 is ignored, word holds steady.
    tk_ready  = 1'b0;
    inc_valid = 1'b1;
    inc_two   = 1'b0;
    tick();
    check("step1_inc_ready", {63'h0, inc_ready}, 64'h0);
    tick();
    inc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'h0, tk_valid}, 64'h1);
      check("hold_tk_o", tk_o, 64'h0200_0000_0000_0077);
      tick();
    end
    expect_word(64'h0200_0000_0000_0077, 1'b0);
    tk_ready = 1'b1;
    wait_drain();

    // Reset in STEP2 clears everything.
    inc_valid = 1'b1;
    inc_two   = 1'b1;
    tick();
    inc_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_step2_tk_o", tk_o, 64'h0);
    check("rst_step2_flags", {61'h0, tk_valid, inc_ready, ctr_wrap}, 64'h0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
